// File: rtl/board_xfer_ctrl_if.sv
// Nios/link side signal bundle of the board transfer controller.
// The slave modport is the controller; the master modport is the Nios/link environment.
interface board_xfer_ctrl_if #(
  parameter int FRAME_W = 256
);
  logic               send_req;
  logic [FRAME_W-1:0] board_in;
  logic               rx_ack;
  logic               remote_ready;
  logic               link_tx_done;
  logic               link_rx_valid;
  logic [FRAME_W-1:0] rx_frame;

  logic               link_start;
  logic [FRAME_W-1:0] tx_frame;
  logic               local_ready;
  logic [FRAME_W-1:0] board_out;
  logic               rx_pending;
  logic               my_turn;
  logic               busy;
  logic               tx_ok;
  logic               tx_err;

  modport slave (
    input  send_req, board_in, rx_ack, remote_ready, link_tx_done, link_rx_valid, rx_frame,
    output link_start, tx_frame, local_ready, board_out, rx_pending, my_turn, busy, tx_ok, tx_err
  );

  modport master (
    output send_req, board_in, rx_ack, remote_ready, link_tx_done, link_rx_valid, rx_frame,
    input  link_start, tx_frame, local_ready, board_out, rx_pending, my_turn, busy, tx_ok, tx_err
  );
endinterface

// File: rtl/board_xfer_ctrl.sv
// Half-duplex board frame exchange sequencer between the Nios board image and the
// board-to-board serial link: send handshake with timeout/retry, receive hold, turn tracking.
module board_xfer_ctrl #(
  parameter int FRAME_W        = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3,
  parameter bit FIRST_TURN     = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  board_xfer_ctrl_if.slave xfer_if
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_PEER = 2'd1,
    S_SEND      = 2'd2
  } state_e;

  state_e             state_q,      state_d;
  logic               send_req_q,   send_req_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [RTY_W-1:0]   rty_q,        rty_d;
  logic               link_start_q, link_start_d;
  logic               tx_ok_q,      tx_ok_d;
  logic               tx_err_q,     tx_err_d;
  logic               my_turn_q,    my_turn_d;
  logic               rx_pending_q, rx_pending_d;
  logic [FRAME_W-1:0] tx_frame_q,   tx_frame_d;
  logic [FRAME_W-1:0] board_out_q,  board_out_d;

  logic send_rise;
  logic rx_accept;

  // NOTE: reset is sampled on the clock edge, and the wide frame registers are
  // cleared too so an aborted transfer leaves no stale frame on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      send_req_q   <= 1'b0;
      cnt_q        <= '0;
      rty_q        <= '0;
      link_start_q <= 1'b0;
      tx_ok_q      <= 1'b0;
      tx_err_q     <= 1'b0;
      my_turn_q    <= FIRST_TURN;
      rx_pending_q <= 1'b0;
      tx_frame_q   <= '0;
      board_out_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      send_req_q   <= send_req_d;
      cnt_q        <= cnt_d;
      rty_q        <= rty_d;
      link_start_q <= link_start_d;
      tx_ok_q      <= tx_ok_d;
      tx_err_q     <= tx_err_d;
      my_turn_q    <= my_turn_d;
      rx_pending_q <= rx_pending_d;
      tx_frame_q   <= tx_frame_d;
      board_out_q  <= board_out_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value is defaulted first so no latch is inferred.
    state_d      = state_q;
    send_req_d   = xfer_if.send_req;
    cnt_d        = cnt_q;
    rty_d        = rty_q;
    link_start_d = 1'b0;
    tx_ok_d      = 1'b0;
    tx_err_d     = tx_err_q;
    my_turn_d    = my_turn_q;
    tx_frame_d   = tx_frame_q;
    board_out_d  = board_out_q;

    send_rise = xfer_if.send_req & ~send_req_q;

    // An acknowledge frees the holding slot before a same-cycle frame is considered.
    rx_pending_d = rx_pending_q & ~xfer_if.rx_ack;
    rx_accept    = (state_q != S_SEND) & xfer_if.link_rx_valid & ~rx_pending_d;

    if (rx_accept) begin
      board_out_d  = xfer_if.rx_frame;
      rx_pending_d = 1'b1;
      my_turn_d    = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (send_rise && !xfer_if.link_rx_valid) begin
          if (my_turn_q) begin
            tx_frame_d = xfer_if.board_in;
            tx_err_d   = 1'b0;
            cnt_d      = '0;
            rty_d      = '0;
            state_d    = S_WAIT_PEER;
          end else begin
            tx_err_d = 1'b1;
          end
        end
      end

      S_WAIT_PEER: begin
        // A frame arriving now means the peer moved first: the send is abandoned.
        if (xfer_if.link_rx_valid) begin
          tx_err_d = 1'b1;
          state_d  = S_IDLE;
        end else if (xfer_if.remote_ready) begin
          link_start_d = 1'b1;
          state_d      = S_SEND;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          rty_d = rty_q + 1'b1;
          if (rty_q == RTY_LAST) begin
            tx_err_d = 1'b1;
            state_d  = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SEND: begin
        if (xfer_if.link_tx_done) begin
          tx_ok_d   = 1'b1;
          my_turn_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign xfer_if.link_start  = link_start_q;
  assign xfer_if.tx_frame    = tx_frame_q;
  assign xfer_if.board_out   = board_out_q;
  assign xfer_if.rx_pending  = rx_pending_q;
  assign xfer_if.my_turn     = my_turn_q;
  assign xfer_if.tx_ok       = tx_ok_q;
  assign xfer_if.tx_err      = tx_err_q;
  assign xfer_if.busy        = (state_q != S_IDLE);
  assign xfer_if.local_ready = (state_q == S_IDLE) & ~rx_pending_q;

  a_start_in_send : assert property (@(posedge clk) link_start_q |-> (state_q == S_SEND));
  a_ok_in_idle    : assert property (@(posedge clk) tx_ok_q |-> (state_q == S_IDLE));
  a_frame_stable  : assert property (@(posedge clk)
                      (state_q == S_SEND && rst_n) |=> $stable(tx_frame_q));

endmodule
